wos_window_seq: RTL and testbench

Sequencer for the pixel window shift registers of the weighted order statistics filter.
- Accepts a raster pixel stream with a valid/ready handshake and drives the shift enable of the window/line shift chain.
- Tracks column and row position.
- Tells the downstream sort/rank core, via a valid/ready handshake, when the KxK window holds a complete, in-image neighbourhood.
- Sits between the pixel source and the shift_reg/line-buffer chain plus rank core.

---
 rtl/wos_window_seq.sv | 202 ++++++++++++++++++++
 tb/tb_wos_window_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wos_window_seq.sv
// Window sequencer for the weighted order statistics filter: paces the raster pixel stream
// into the window/line shift chain and flags complete in-image KxK windows to the rank core.
// Optional build macro WOS_SEQ_STATS_EN adds win_count/stall_count statistics outputs.
module wos_window_seq #(
    parameter int bits  = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int K     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     in_valid,
    input  logic [bits-1:0]          in_pixel,
    output logic                     in_ready,
    output logic                     shift_en,
    output logic [bits-1:0]          shift_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic                     busy,
    output logic                     frame_done
`ifdef WOS_SEQ_STATS_EN
    ,
    output logic [31:0]              win_count,
    output logic [31:0]              stall_count
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   col_r, col_s, next_col_s;
    logic [RW-1:0]   row_r, row_s, next_row_s;
    logic            first_r, first_s;
    logic            win_valid_r, win_valid_s;
    logic            busy_r, busy_s;
    logic            frame_done_r, frame_done_s;
    logic            in_ready_s, accept_s, start_s;

    // Position of the pixel that would be accepted this cycle; the first pixel starts at (0,0).
    always_comb begin
        next_col_s = col_r;
        next_row_s = row_r;
        if (first_r) begin
            next_col_s = {CW{1'b0}};
            next_row_s = {RW{1'b0}};
        end else if (col_r == COL_LAST) begin
            next_col_s = {CW{1'b0}};
            next_row_s = row_r + {{(RW-1){1'b0}}, 1'b1};
        end else begin
            next_col_s = col_r + {{(CW-1){1'b0}}, 1'b1};
            next_row_s = row_r;
        end
    end

    // Next-state, handshake and position/window update logic.
    always_comb begin
        state_s      = state_r;
        col_s        = col_r;
        row_s        = row_r;
        first_s      = first_r;
        busy_s       = busy_r;
        frame_done_s = 1'b0;
        in_ready_s   = 1'b0;
        accept_s     = 1'b0;
        start_s      = 1'b0;
        win_valid_s  = win_valid_r && !win_ready;
        case (state_r)
            IDLE: begin
                // A start coinciding with the completion pulse is deliberately dropped.
                if (frame_start && !frame_done_r) begin
                    start_s = 1'b1;
                    state_s = RUN;
                    busy_s  = 1'b1;
                    first_s = 1'b1;
                    col_s   = {CW{1'b1}};
                    row_s   = {RW{1'b1}};
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                in_ready_s = !win_valid_r || win_ready;
                accept_s   = in_valid && in_ready_s;
                if (accept_s) begin
                    col_s   = next_col_s;
                    row_s   = next_row_s;
                    first_s = 1'b0;
                    if ((next_col_s >= COL_WIN) && (next_row_s >= ROW_WIN)) begin
                        win_valid_s = 1'b1;
                    end else begin
                        win_valid_s = win_valid_r && !win_ready;
                    end
                    if ((next_col_s == COL_LAST) && (next_row_s == ROW_LAST)) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (!win_valid_r || win_ready) begin
                    state_s      = IDLE;
                    busy_s       = 1'b0;
                    frame_done_s = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and position registers; async reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
            first_r      <= 1'b0;
            win_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            col_r        <= col_s;
            row_r        <= row_s;
            first_r      <= first_s;
            win_valid_r  <= win_valid_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign shift_en   = accept_s;
    assign shift_data = in_pixel;
    assign win_valid  = win_valid_r;
    assign col        = col_r;
    assign row        = row_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

`ifdef WOS_SEQ_STATS_EN
    logic [31:0] win_count_r, win_count_s;
    logic [31:0] stall_count_r, stall_count_s;

    // Statistics next values; cleared by an accepted frame start, held after completion.
    always_comb begin
        win_count_s   = win_count_r;
        stall_count_s = stall_count_r;
        if (start_s) begin
            win_count_s   = 32'd0;
            stall_count_s = 32'd0;
        end else begin
            if (win_valid_r && win_ready) begin
                win_count_s = win_count_r + 32'd1;
            end else begin
                win_count_s = win_count_r;
            end
            if ((state_r == RUN) && in_valid && !in_ready_s) begin
                stall_count_s = stall_count_r + 32'd1;
            end else begin
                stall_count_s = stall_count_r;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_count_r   <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            win_count_r   <= win_count_s;
            stall_count_r <= stall_count_s;
        end
    end

    assign win_count   = win_count_r;
    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_wos_window_seq.sv
// Scoreboard bench for wos_window_seq on a 4x3 image with a 3x3 window: the driver queues
// expected pixels and window positions, a negedge monitor pops and compares them.
module tb_wos_window_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = 8'd0;
    logic       in_ready, shift_en, win_valid, busy, frame_done;
    logic [7:0] shift_data;
    logic       win_ready = 1'b1;
    logic [1:0] col;
    logic [1:0] row;
`ifdef WOS_SEQ_STATS_EN
    logic [31:0] win_count, stall_count;
`endif

    int checks = 0;
    int errors = 0;
    int n_win  = 0;
    int n_done = 0;
    logic [7:0] pix_q[$];
    int         win_q[$];   // expected window position encoded col*16+row

    wos_window_seq #(.bits(8), .IMG_W(4), .IMG_H(3), .K(3)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
        .in_pixel(in_pixel), .in_ready(in_ready), .shift_en(shift_en),
        .shift_data(shift_data), .win_valid(win_valid), .win_ready(win_ready),
        .col(col), .row(row), .busy(busy), .frame_done(frame_done)
`ifdef WOS_SEQ_STATS_EN
        , .win_count(win_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop expected pixels on shift_en and expected windows on consumption.
    always @(negedge clk) begin
        if (rst) begin
            if (shift_en) begin
                if (pix_q.size() == 0) chk("unexpected_shift_en", 32'd1, 32'd0);
                else chk("shift_data", 32'(shift_data), 32'(pix_q.pop_front()));
            end
            if (win_valid && win_ready) begin
                n_win++;
                if (win_q.size() == 0) chk("unexpected_window", 32'd1, 32'd0);
                else chk("window_pos", 32'(col) * 32'd16 + 32'(row), 32'(win_q.pop_front()));
            end
            if (frame_done) n_done++;
        end
    end

    task automatic send(input logic [7:0] p);
        int t;
        t = 0;
        pix_q.push_back(p);
        in_pixel = p;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        chk("send_accepted", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic push_windows();
        win_q.push_back(2 * 16 + 2);
        win_q.push_back(3 * 16 + 2);
    endtask

    task automatic end_of_frame(input string tag, input int w0, input int d0);
        @(negedge clk);
        chk({tag, "_windows"}, 32'(n_win - w0), 32'd2);
        chk({tag, "_frame_done_count"}, 32'(n_done - d0), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_queues_empty"}, 32'(win_q.size() + pix_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, d0;
        // Reset state
        #2 rst = 1'b0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_col_row", 32'(col) * 32'd16 + 32'(row), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // T1: back-to-back frame, rank core always ready
        w0 = n_win; d0 = n_done;
        push_windows();
        pulse_start();
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_col_row_ones", 32'(col) * 32'd16 + 32'(row), 32'd51);
        chk("start_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        for (int p = 1; p <= 12; p++) send(8'(p));
        @(negedge clk);
        chk("t1_last_win_valid", 32'(win_valid), 32'd1);
        chk("t1_done_early", 32'(frame_done), 32'd0);
        @(negedge clk);
        chk("t1_frame_done", 32'(frame_done), 32'd1);
        chk("t1_busy_cleared", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(frame_done), 32'd0);
`ifdef WOS_SEQ_STATS_EN
        chk("t1_win_count", win_count, 32'd2);
        chk("t1_stall_count", stall_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        end_of_frame("t1", w0, d0);

        // T2: rank core stalls for 5 cycles after the first window
        w0 = n_win; d0 = n_done;
        push_windows();
        pulse_start();
`ifdef WOS_SEQ_STATS_EN
        @(negedge clk);
        chk("t2_win_count_cleared", win_count, 32'd0);
        @(posedge clk);
        #1;
`endif
        for (int p = 1; p <= 11; p++) send(8'(p));
        win_ready = 1'b0;
        in_pixel  = 8'd12;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_stall_in_ready", 32'(in_ready), 32'd0);
            chk("t2_stall_shift_en", 32'(shift_en), 32'd0);
            chk("t2_stall_win_held", 32'(win_valid), 32'd1);
        end
        @(posedge clk);
        #1 win_ready = 1'b1;
        send(8'd12);
        wait_done();
`ifdef WOS_SEQ_STATS_EN
        chk("t2_stall_count", stall_count, 32'd5);
        chk("t2_win_count", win_count, 32'd2);
`endif
        end_of_frame("t2", w0, d0);

        // T3: source valid toggles, positions advance only on accepts
        w0 = n_win; d0 = n_done;
        push_windows();
        pulse_start();
        for (int p = 1; p <= 12; p++) begin
            send(8'(p));
            @(negedge clk);
            chk("t3_col", 32'(col), 32'((p - 1) % 4));
            chk("t3_row", 32'(row), 32'((p - 1) / 4));
            @(posedge clk);
            #1;
        end
        wait_done();
        end_of_frame("t3", w0, d0);

        // T4: reset mid-frame after pixel 7
        d0 = n_done;
        pulse_start();
        for (int p = 1; p <= 7; p++) send(8'(p));
        rst = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_col_row", 32'(col) * 32'd16 + 32'(row), 32'd0);
        chk("t4_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t4_rst_win_valid", 32'(win_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_frame_done", 32'(n_done - d0), 32'd0);
        w0 = n_win; d0 = n_done;
        push_windows();
        pulse_start();
        send(8'd1);
        @(negedge clk);
        chk("t4_first_col_row", 32'(col) * 32'd16 + 32'(row), 32'd0);
        @(posedge clk);
        #1;
        for (int p = 2; p <= 12; p++) send(8'(p));
        wait_done();
        end_of_frame("t4", w0, d0);

        // T5: frame_start mid-frame and on the frame_done cycle is ignored
        w0 = n_win; d0 = n_done;
        push_windows();
        pulse_start();
        for (int p = 1; p <= 5; p++) send(8'(p));
        pulse_start();
        @(negedge clk);
        chk("t5_mid_start_col_row", 32'(col) * 32'd16 + 32'(row), 32'd1);
        chk("t5_mid_start_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        for (int p = 6; p <= 12; p++) send(8'(p));
        @(posedge clk);
        #1;
        chk("t5_done_cycle", 32'(frame_done), 32'd1);
        pulse_start();
        @(negedge clk);
        chk("t5_start_on_done_busy", 32'(busy), 32'd0);
        chk("t5_start_on_done_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        end_of_frame("t5", w0, d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
